// File: rtl/alu_issue_unit.sv
// Issue stage for a slow external ALU: operands are held SETTLE cycles, result written back SETTLE+1 cycles after accept.
// Loads write back the cycle after accept; req_ready drops while waiting and requests seen then are dropped.
module alu_issue_unit #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_cin,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [WIDTH-1:0] req_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_eq,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_eq,
  output logic             busy,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] regs [32];
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  // r0 is hardwired to zero on every read path, so its storage never matters
  assign rs_val    = (req_rs == 5'd0)   ? '0 : regs[req_rs];
  assign rt_val    = (req_rt == 5'd0)   ? '0 : regs[req_rt];
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
  assign req_ready = (state == IDLE);
  assign busy      = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= 1'b0;
      alu_cin  <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_eq    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_op == 2'b10) begin
              if (req_rd != 5'd0) regs[req_rd] <= req_imm;
              wb_valid <= 1'b1;
              wb_rd    <= req_rd;
              wb_data  <= req_imm;
              wb_eq    <= 1'b0;
            end else begin
              // op 11 is reserved and falls through to NOR via bit 0
              alu_a   <= rs_val;
              alu_b   <= rt_val;
              alu_op  <= req_op[0];
              alu_cin <= req_cin;
              rd_q    <= req_rd;
              cnt     <= 8'(SETTLE - 1);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (rd_q != 5'd0) regs[rd_q] <= alu_out;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= alu_out;
            wb_eq    <= alu_eq;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU on the operand pins, register-file reference model, directed plus random ops.
`timescale 1ns/1ps
module tb_alu_issue_unit;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic        req_cin = 1'b0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [31:0] req_imm = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_op, alu_cin, alu_eq;
  logic        wb_valid, wb_eq, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  // external ALU: ripple add or NOR, plus equality
  assign alu_out = alu_op ? ~(alu_a | alu_b) : alu_a + alu_b + {31'b0, alu_cin};
  assign alu_eq  = (alu_a == alu_b);

  alu_issue_unit #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cin(req_cin), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cin(alu_cin), .alu_out(alu_out), .alu_eq(alu_eq),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eq(wb_eq),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {31'b0, alu_op}, 32'd0);
    chk("rst_alu_cin", {31'b0, alu_cin}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_eq", {31'b0, wb_eq}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_dbg_all_zero();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      chk("rst_dbg", dbg_data, 32'd0);
    end
  endtask

  // Starts just after an accept edge; expects operands held through SETTLE edges, then writeback
  task automatic window(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic cin, input logic [4:0] rd);
    logic [31:0] res;
    res = (op == 2'b00) ? a + b + {31'b0, cin} : ~(a | b);
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      chk("hold_alu_a", alu_a, a);
      chk("hold_alu_b", alu_b, b);
      chk("hold_alu_op", {31'b0, alu_op}, {31'b0, op != 2'b00});
      chk("hold_alu_cin", {31'b0, alu_cin}, {31'b0, cin});
      chk("wait_busy", {31'b0, busy, req_ready}, 32'd2);
      chk("wait_no_wb", {31'b0, wb_valid}, 32'd0);
    end
    @(negedge clk);
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
    chk("wb_data", wb_data, res);
    chk("wb_eq", {31'b0, wb_eq}, {31'b0, a == b});
    chk("wb_ready", {31'b0, busy, req_ready}, 32'd1);
    if (rd != 5'd0) mregs[rd] = res;
    dbg_addr = rd;
    #0.1;
    chk("wb_dbg", dbg_data, mregs[rd]);
  endtask

  // All request tasks start and end at (just after) a falling edge
  task automatic do_alu(input logic [1:0] op, input logic cin, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    logic [31:0] a, b;
    a = mregs[rs];
    b = mregs[rt];
    req_valid = 1'b1; req_op = op; req_cin = cin;
    req_rs = rs; req_rt = rt; req_rd = rd; req_imm = $urandom;
    @(posedge clk);
    #1 req_valid = 1'b0;
    window(a, b, op, cin, rd);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [31:0] imm);
    logic [31:0] pa, pb;
    pa = alu_a;
    pb = alu_b;
    req_valid = 1'b1; req_op = 2'b10; req_rd = rd; req_imm = imm;
    req_rs = 5'($urandom); req_rt = 5'($urandom); req_cin = 1'($urandom);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("ld_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
    chk("ld_wb_data", wb_data, imm);
    chk("ld_wb_eq", {31'b0, wb_eq}, 32'd0);
    chk("ld_idle", {31'b0, busy, req_ready}, 32'd1);
    chk("ld_alu_a_kept", alu_a, pa);
    chk("ld_alu_b_kept", alu_b, pb);
    if (rd != 5'd0) mregs[rd] = imm;
    dbg_addr = rd;
    #0.1;
    chk("ld_dbg", dbg_data, mregs[rd]);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] a, b;
    clear_model();
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // dirty some state, then reset mid-cycle
    do_load(5'd9, 32'h1234_5678);
    do_alu(2'b00, 1'b1, 5'd9, 5'd9, 5'd10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    chk_dbg_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    #0.1 chk("rel_ready", {31'b0, req_ready}, 32'd1);

    // add 1+1
    do_load(5'd1, 32'd1);
    do_load(5'd2, 32'd1);
    do_alu(2'b00, 1'b0, 5'd1, 5'd2, 5'd3);
    chk("add_r3", dbg_data, 32'd2);
    chk("add_eq", {31'b0, wb_eq}, 32'd1);

    // NOR r0, r4
    do_load(5'd4, 32'd3);
    do_alu(2'b01, 1'b0, 5'd0, 5'd4, 5'd5);
    chk("nor_r5", dbg_data, 32'hFFFF_FFFC);

    // r0 protection
    do_load(5'd0, 32'hDEAD_BEEF);
    chk("r0_read", dbg_data, 32'd0);
    do_alu(2'b00, 1'b0, 5'd0, 5'd1, 5'd8);
    chk("r0_add", dbg_data, 32'd1);

    // continuous valid, dependent pair
    req_valid = 1'b1; req_op = 2'b00; req_cin = 1'b0;
    req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd6;
    @(posedge clk);
    #1 req_rs = 5'd6; req_rt = 5'd1; req_rd = 5'd7;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready) seen = 1'b1;
      else chk("pair_hold_a", alu_a, mregs[1]);
    end
    chk("pair_gap", 32'(n), 32'(SETTLE + 1));
    chk("pair_wb1", wb_data, mregs[1] + mregs[1]);
    mregs[6] = mregs[1] + mregs[1];
    a = mregs[6];
    b = mregs[1];
    @(posedge clk);
    #1 req_valid = 1'b0;
    window(a, b, 2'b00, 1'b0, 5'd7);
    chk("pair_r7", dbg_data, 32'd3);

    // load then immediately read it
    do_load(5'd11, 32'h0000_00F0);
    do_alu(2'b11, 1'b0, 5'd11, 5'd0, 5'd12);
    chk("ld_use_r12", dbg_data, 32'hFFFF_FF0F);

    // reset during WAIT cycle 2
    req_valid = 1'b1; req_op = 2'b00; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd13;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < SETTLE + 2; i++) begin
      @(negedge clk);
      chk("abort_no_wb", {31'b0, wb_valid, busy}, 32'd0);
    end
    chk_dbg_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    do_load(5'd14, 32'hA5A5_0001);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10)
        do_load(5'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      else
        do_alu(op, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
